fetch_queue_stage: RTL and testbench
====================================

Name: fetch_queue_stage

Overview:
Parametrised successor to the single-register fetch stage of the 5-stage pipeline CPU. It decouples PC generation from decode through a DEPTH-entry prefetch queue, and talks to a variable-latency, in-order instruction memory over a req/rsp handshake. It accepts EX-stage redirects (taken branch, jal, jalr), flushing queued and in-flight instructions. It drives ID with a valid/ready pair in place of StallD/FlushD.

Parameters:
XLEN, 32, PC/address width
DEPTH, 4, queue entries; also the max in-flight memory requests (power of 2, >=2)
RESET_PC, 0, first fetch address after reset

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (reset==0 clears all state)
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  fetch address (word aligned)
imem_rsp_valid  in  1  response valid; responses in request order, >=1 cycle after acceptance
imem_rsp_data  in  32  instruction word
redirect_valid  in  1  EX redirect (PCSrc)
redirect_pc  in  XLEN  redirect target (PC_branch)
id_valid  out  1  queue head valid
id_ready  in  1  ID consumes head (deasserted = stall)
id_instr  out  32  head instruction
id_pc  out  XLEN  head PC
id_pc_plus4  out  XLEN  head PC+4, modulo 2^XLEN
occupancy  out  clog2(DEPTH+1)  valid queue entries

Behaviour:
- Reset (async, reset==0): fetch_pc=RESET_PC, rsp_pc=RESET_PC, queue empty, inflight=0, drop_cnt=0. Outputs: imem_req_valid=0, id_valid=0, occupancy=0, id_instr/id_pc/id_pc_plus4=0. Memory is reset together with this block.
- Credits: imem_req_valid = !redirect_valid && (occupancy + inflight - drop_cnt < DEPTH). imem_req_addr = fetch_pc.
- Issue: on imem_req_valid&&imem_req_ready, fetch_pc += 4 (wraps modulo 2^XLEN) and inflight += 1.
- Response: imem_rsp_valid decrements inflight.
  - If drop_cnt>0, the word is discarded and drop_cnt -= 1.
  - Otherwise {rsp_pc, imem_rsp_data} is pushed at the tail and rsp_pc += 4.
  - A response while inflight==0 is ignored (protocol error).
- Pop: id_valid&&id_ready removes the head.
- id_valid = occupancy!=0. id_* are driven from the head entry (registered storage). Latency from response to id_valid is 1 cycle.
- Push and pop in the same cycle: both happen, occupancy unchanged. A push at full cannot occur because credits guarantee space.
- Redirect (priority over issue, push and pop):
  - next cycle: queue empty, occupancy=0, id_valid=0, fetch_pc=rsp_pc=redirect_pc.
  - drop_cnt = inflight after this cycle's response decrement (inflight - rsp_valid).
  - A response arriving in the redirect cycle is discarded.
  - A pop in the redirect cycle is ignored.
  - The first post-redirect request is issued the cycle after the redirect.
- Back-to-back redirects: the later one wins. drop_cnt is recomputed from inflight, never double-counted.
- Invariants: inflight<=DEPTH; drop_cnt<=inflight; occupancy+inflight-drop_cnt<=DEPTH.
- Queue is a circular buffer with clog2(DEPTH) pointers that wrap naturally; full/empty is resolved by the occupancy count.

Test Plan:
- Reset release, mem ready=1, latency 1, id_ready=1 -> id_pc sequence 0,4,8,12… one per cycle after a 2-cycle fill; id_pc_plus4=id_pc+4.
- id_ready=0 for 10 cycles, latency 1 -> occupancy saturates at 4, inflight=0, imem_req_valid=0; on release, PCs 0,4,8,12 drain in order with no loss or duplication.
- Latency 3, 3 in flight, redirect_pc=0x100 -> 3 stale responses dropped; next id_pc=0x100 with the instruction from address 0x100.
- Redirect in the same cycle as a response and a pop -> queue empty next cycle, that response not delivered, drop_cnt correct, no underflow.
- XLEN=32, RESET_PC=0xFFFFFFF8 -> PCs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; id_pc_plus4 of the last entry = 0x4.
- reset asserted mid-stream with queue partly full -> all outputs 0 immediately (asynchronous); after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_queue_stage_if.sv
// Fetch queue stage handshake bundle: imem req/rsp, EX redirect, ID valid/ready.
// master = fetch stage side, slave = memory / EX / ID environment side.
interface fetch_queue_stage_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int OW = $clog2(DEPTH + 1);

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_valid;
  logic            id_ready;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_pc_plus4;
  logic [OW-1:0]   occupancy;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output id_valid, id_instr, id_pc,
    output id_pc_plus4, occupancy,
    input  id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  id_valid, id_instr, id_pc,
    input  id_pc_plus4, occupancy,
    output id_ready
  );
endinterface

// File: rtl/fetch_queue_stage.sv
// Prefetching fetch stage: credit-limited imem requests, DEPTH-entry queue to ID.
// Ports: clk, reset (async active-low), io (fetch_queue_stage_if.master).
module fetch_queue_stage #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic reset,
  fetch_queue_stage_if.master io
);
  localparam int OW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = OW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          hd;
  logic [PW-1:0]   head, tail;
  logic [OW-1:0]   occ, inflight, drop_cnt;
  logic [XLEN-1:0] fetch_pc, rsp_pc;
  logic [CW-1:0]   used;
  logic            redir, credit, issue;
  logic            rsp_ok, drop, push, pop;

  // Words still owed by memory that will be kept count against the queue.
  assign used   = CW'(occ) + CW'(inflight)
                - CW'(drop_cnt);
  assign credit = used < CW'(DEPTH);
  assign redir  = io.redirect_valid;

  assign io.imem_req_valid = reset && !redir
                           && credit;
  assign io.imem_req_addr  = fetch_pc;

  assign issue  = io.imem_req_valid
               && io.imem_req_ready;
  // A response with nothing outstanding is ignored.
  assign rsp_ok = io.imem_rsp_valid
               && (inflight != '0);
  assign drop   = rsp_ok && (drop_cnt != '0);
  assign push   = rsp_ok && !drop && !redir;
  assign pop    = io.id_valid && io.id_ready
               && !redir;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      occ      <= '0;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= inflight + OW'(issue)
                - OW'(rsp_ok);
      if (redir) begin
        // Everything still in flight is stale.
        drop_cnt <= inflight - OW'(rsp_ok);
        fetch_pc <= io.redirect_pc;
        rsp_pc   <= io.redirect_pc;
        head     <= '0;
        tail     <= '0;
        occ      <= '0;
      end else begin
        if (issue)
          fetch_pc <= fetch_pc + XLEN'(4);
        if (drop)
          drop_cnt <= drop_cnt - OW'(1);
        if (push) begin
          tail   <= tail + PW'(1);
          rsp_pc <= rsp_pc + XLEN'(4);
        end
        if (pop)
          head <= head + PW'(1);
        occ <= occ + OW'(push) - OW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[tail] <= '{pc: rsp_pc,
                     instr: io.imem_rsp_data};
  end

  assign hd = mem[head];

  // Outputs read zero whenever the queue is empty.
  assign io.id_valid    = occ != '0;
  assign io.occupancy   = occ;
  assign io.id_pc       = io.id_valid ? hd.pc : '0;
  assign io.id_instr    = io.id_valid ? hd.instr : '0;
  assign io.id_pc_plus4 = io.id_valid
                        ? hd.pc + XLEN'(4) : '0;
endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage: stream, stall, redirects, wrap, reset.
// Two instances: RESET_PC=0 (variable-latency memory) and RESET_PC=0xFFFFFFF8.
module tb_fetch_queue_stage;
  logic clk = 0;
  logic reset = 0;
  int   errors = 0;
  int   checks = 0;
  int   lat = 1;
  int   cyc = 0;

  always #5 clk = ~clk;

  fetch_queue_stage_if #(.XLEN(32), .DEPTH(4)) io ();
  fetch_queue_stage_if #(.XLEN(32), .DEPTH(4)) wio ();

  fetch_queue_stage #(
    .XLEN(32), .DEPTH(4), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .reset(reset), .io(io.master)
  );

  fetch_queue_stage #(
    .XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)
  ) dut_w (
    .clk(clk), .reset(reset), .io(wio.master)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t q[$];

  // In-order memory for dut, latency lat edges.
  always @(posedge clk) begin
    if (reset) begin
      if (io.imem_rsp_valid && q.size() > 0)
        q.delete(0);
      if (io.imem_req_valid && io.imem_req_ready)
        q.push_back('{io.imem_req_addr, cyc + lat});
    end
    cyc++;
    #1;
    if (reset && q.size() > 0 && q[0].due <= cyc) begin
      io.imem_rsp_valid = 1;
      io.imem_rsp_data  = ~q[0].addr;
    end else begin
      io.imem_rsp_valid = 0;
      io.imem_rsp_data  = '0;
    end
  end

  always @(negedge reset) begin
    q.delete();
    io.imem_rsp_valid = 0;
    wio.imem_rsp_valid = 0;
  end

  // Latency-1 memory for dut_w.
  logic        w_acc;
  logic [31:0] w_addr;
  always @(posedge clk) begin
    w_acc  = reset && wio.imem_req_valid
          && wio.imem_req_ready;
    w_addr = wio.imem_req_addr;
    #1;
    wio.imem_rsp_valid = w_acc && reset;
    wio.imem_rsp_data  = ~w_addr;
  end

  initial begin
    io.imem_req_ready  = 1;
    io.imem_rsp_valid  = 0;
    io.imem_rsp_data   = '0;
    io.redirect_valid  = 0;
    io.redirect_pc     = '0;
    io.id_ready        = 1;
    wio.imem_req_ready = 1;
    wio.imem_rsp_valid = 0;
    wio.imem_rsp_data  = '0;
    wio.redirect_valid = 0;
    wio.redirect_pc    = '0;
    wio.id_ready       = 1;
  end

  // Returns at a negedge with reset just released.
  task automatic do_reset(input int l);
    @(negedge clk);
    reset = 0;
    io.redirect_valid = 0;
    io.id_ready = 1;
    lat = l;
    repeat (2) @(negedge clk);
    reset = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2 reset = 0;
    #1;
    checks++;
    if (io.imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_req_valid got=%b exp=0",
               io.imem_req_valid);
    end
    checks++;
    if (io.id_valid !== 1'b0 || io.occupancy !== 0) begin
      errors++;
      $display("FAIL reset_id got v=%b occ=%0d exp 0/0",
               io.id_valid, io.occupancy);
    end
    checks++;
    if (io.id_pc !== 0 || io.id_instr !== 0
        || io.id_pc_plus4 !== 0) begin
      errors++;
      $display("FAIL reset_id_data got %h %h %h exp 0",
               io.id_pc, io.id_instr, io.id_pc_plus4);
    end
    checks++;
    if (io.imem_req_addr !== 32'h0
        || wio.imem_req_addr !== 32'hFFFF_FFF8) begin
      errors++;
      $display("FAIL reset_addr got %h %h exp 0 fffffff8",
               io.imem_req_addr, wio.imem_req_addr);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp = 0;
    int first = -1;
    int nv = 0;
    do_reset(1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (io.id_valid) begin
        if (first < 0) first = c;
        nv++;
        checks++;
        if (io.id_pc !== exp
            || io.id_instr !== ~exp
            || io.id_pc_plus4 !== exp + 32'd4) begin
          errors++;
          $display("FAIL stream_pc got %h/%h/%h exp %h",
                   io.id_pc, io.id_instr,
                   io.id_pc_plus4, exp);
        end
        exp += 4;
      end
    end
    checks++;
    if (first != 1 || nv != 19) begin
      errors++;
      $display("FAIL stream_rate got first=%0d n=%0d exp 1 19",
               first, nv);
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp = 0;
    int n = 0;
    do_reset(1);
    io.id_ready = 0;
    repeat (10) @(negedge clk);
    checks++;
    if (io.occupancy !== 4 || io.imem_req_valid !== 0) begin
      errors++;
      $display("FAIL stall_full got occ=%0d rv=%b exp 4 0",
               io.occupancy, io.imem_req_valid);
    end
    checks++;
    if (q.size() != 0 || io.imem_rsp_valid !== 0) begin
      errors++;
      $display("FAIL stall_inflight got %0d exp 0", q.size());
    end
    io.id_ready = 1;
    for (int k = 0; k < 10; k++) begin
      if (io.id_valid) begin
        n++;
        checks++;
        if (io.id_pc !== exp || io.id_instr !== ~exp) begin
          errors++;
          $display("FAIL stall_drain got %h/%h exp %h",
                   io.id_pc, io.id_instr, exp);
        end
        exp += 4;
      end
      @(negedge clk);
    end
    checks++;
    if (n < 5) begin
      errors++;
      $display("FAIL stall_count got %0d exp >=5", n);
    end
  endtask

  // Wait for the first delivered word after a redirect.
  task automatic expect_first(input string nm,
                              input logic [31:0] pc);
    bit seen = 0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      if (io.id_valid) begin
        seen = 1;
        checks++;
        if (io.id_pc !== pc || io.id_instr !== ~pc) begin
          errors++;
          $display("FAIL %s_first got %h/%h exp %h",
                   nm, io.id_pc, io.id_instr, pc);
        end
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout got no id_valid exp %h",
               nm, pc);
    end
    @(negedge clk);
    checks++;
    if (io.id_valid !== 1'b1 || io.id_pc !== pc + 4) begin
      errors++;
      $display("FAIL %s_next got v=%b pc=%h exp %h",
               nm, io.id_valid, io.id_pc, pc + 4);
    end
  endtask

  task automatic test_redirect_latency();
    do_reset(3);
    repeat (3) @(negedge clk);
    checks++;
    if (io.imem_rsp_valid !== 1 || q.size() != 3) begin
      errors++;
      $display("FAIL redir3_pre got rsp=%b n=%0d exp 1 3",
               io.imem_rsp_valid, q.size());
    end
    io.redirect_valid = 1;
    io.redirect_pc = 32'h100;
    #1;
    checks++;
    if (io.imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir3_block got %b exp 0",
               io.imem_req_valid);
    end
    @(negedge clk);
    io.redirect_valid = 0;
    #1;
    checks++;
    if (io.occupancy !== 0 || io.id_valid !== 0
        || io.imem_req_addr !== 32'h100
        || io.imem_req_valid !== 1) begin
      errors++;
      $display("FAIL redir3_post got occ=%0d a=%h rv=%b",
               io.occupancy, io.imem_req_addr,
               io.imem_req_valid);
    end
    expect_first("redir3", 32'h100);
  endtask

  task automatic test_redirect_collide();
    do_reset(1);
    repeat (5) @(negedge clk);
    checks++;
    if (io.id_valid !== 1 || io.imem_rsp_valid !== 1) begin
      errors++;
      $display("FAIL collide_pre got v=%b rsp=%b exp 1 1",
               io.id_valid, io.imem_rsp_valid);
    end
    io.redirect_valid = 1;
    io.redirect_pc = 32'h200;
    @(negedge clk);
    io.redirect_valid = 0;
    #1;
    checks++;
    if (io.occupancy !== 0 || io.id_valid !== 0
        || io.id_pc !== 0
        || io.imem_req_addr !== 32'h200) begin
      errors++;
      $display("FAIL collide_post got occ=%0d pc=%h a=%h",
               io.occupancy, io.id_pc, io.imem_req_addr);
    end
    expect_first("collide", 32'h200);
  endtask

  task automatic test_back_to_back();
    do_reset(2);
    repeat (6) @(negedge clk);
    io.redirect_valid = 1;
    io.redirect_pc = 32'h300;
    @(negedge clk);
    io.redirect_pc = 32'h400;
    @(negedge clk);
    io.redirect_valid = 0;
    #1;
    checks++;
    if (io.imem_req_addr !== 32'h400) begin
      errors++;
      $display("FAIL b2b_addr got %h exp 400",
               io.imem_req_addr);
    end
    expect_first("b2b", 32'h400);
  endtask

  task automatic test_wrap();
    logic [31:0] exp = 32'hFFFF_FFF8;
    int n = 0;
    do_reset(1);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (wio.id_valid && n < 4) begin
        n++;
        checks++;
        if (wio.id_pc !== exp || wio.id_instr !== ~exp
            || wio.id_pc_plus4 !== exp + 32'd4) begin
          errors++;
          $display("FAIL wrap_pc got %h/%h/%h exp %h",
                   wio.id_pc, wio.id_instr,
                   wio.id_pc_plus4, exp);
        end
        if (n == 3) begin
          checks++;
          if (wio.id_pc_plus4 !== 32'h4) begin
            errors++;
            $display("FAIL wrap_plus4 got %h exp 4",
                     wio.id_pc_plus4);
          end
        end
        exp += 4;
      end
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL wrap_count got %0d exp 4", n);
    end
  endtask

  task automatic test_async_reset();
    do_reset(1);
    io.id_ready = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (io.occupancy !== 2) begin
      errors++;
      $display("FAIL areset_pre got occ=%0d exp 2",
               io.occupancy);
    end
    #2 reset = 0;
    #1;
    checks++;
    if (io.occupancy !== 0 || io.id_valid !== 0
        || io.imem_req_valid !== 0
        || io.id_pc !== 0 || io.id_instr !== 0
        || io.id_pc_plus4 !== 0) begin
      errors++;
      $display("FAIL areset_out got occ=%0d v=%b rv=%b pc=%h",
               io.occupancy, io.id_valid,
               io.imem_req_valid, io.id_pc);
    end
    io.id_ready = 1;
    @(negedge clk);
    reset = 1;
    #1;
    checks++;
    if (io.imem_req_addr !== 0 || io.imem_req_valid !== 1) begin
      errors++;
      $display("FAIL areset_restart got a=%h rv=%b exp 0 1",
               io.imem_req_addr, io.imem_req_valid);
    end
    expect_first("areset", 32'h0);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_latency();
    test_redirect_collide();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
endmodule
